regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 64-entry register file. It accepts write-back requests from up to NUM_SRC execution units and grants one per cycle in round-robin order. It drives the single register file write port: registered address, data and decoded 64-bit one-hot enable. It also tracks which registers have an issued-but-uncommitted write, so the issue stage can stall on hazards.

## Interface
- NUM_SRC, 4, number of write-back requesters (2..8)
- DATA_W, 64, register data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- src_valid  in  NUM_SRC  per-source write-back request
- src_addr  in  6*NUM_SRC  destination register; source i uses bits [6i+5:6i]
- src_data  in  DATA_W*NUM_SRC  write data; source i uses slice i
- src_ready  out  NUM_SRC  one-hot grant, combinational; a transfer occurs when valid&ready at an edge
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  6  register file write address (registered)
- wr_data  out  DATA_W  register file write data (registered)
- wr_onehot  out  64  decoded wr_addr, gated by wr_en (registered)
- issue_valid  in  1  issue stage allocates a destination register
- issue_addr  in  6  allocated destination
- busy  out  64  scoreboard; bit n = write to register n pending

## Operation
- Arbitration: rr_ptr (3 bits, values 0..NUM_SRC-1) names the highest-priority source.
  - Grant goes to the first valid source scanning rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - At most one src_ready bit is high, and only for a valid source.
  - src_ready is forced to 0 while rst is high.
- On a transfer from source g, rr_ptr becomes (g+1) mod NUM_SRC. With no transfer, rr_ptr holds.
- Output stage: on a transfer, load wr_addr=src_addr[g] and wr_data=src_data[g].
  - Set wr_en=1 and wr_onehot=1<<addr, except addr 0.
  - Register 0 is hardwired zero: the transfer completes (ready high) but wr_en=0 and wr_onehot=0. wr_addr/wr_data still load.
- With no transfer, wr_en and wr_onehot load 0; wr_addr/wr_data hold.
- The write port is always ready, so sustained throughput is one write per cycle.
- Sources must hold valid, addr and data stable until granted. Dropping valid before grant withdraws the request; it is not an error.
- Scoreboard, per edge:
  - If issue_valid and issue_addr≠0, set busy[issue_addr].
  - If wr_en==1, clear busy[wr_addr].
  - Set and clear to the same address in one edge: set wins (new producer pending).
  - busy[0] is constant 0.
- Clearing a non-busy bit is a no-op. Issuing to an already-busy register is a no-op (no count; one pending write per register is enforced upstream).

## Timing
- Reset values: rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, wr_onehot=0, busy=0.
- Reset applies asynchronously and aborts any in-flight output write: wr_en drops immediately.
- Request to grant: 0 cycles (combinational ready).
- Grant edge to wr_en: wr_en is high for the cycle following the grant edge, lasting exactly one cycle per transfer.
- busy clears at the edge that ends the wr_en cycle, i.e. 2 edges after grant. Consumers see the register file holding new data when busy reads 0.
- Back-to-back grants produce back-to-back wr_en cycles with no bubble.
- Fairness: a continuously valid source is granted within NUM_SRC transfers.

## Test plan
- Reset: assert rst mid-transfer with wr_en=1 → wr_en, wr_onehot and busy are 0 before the next edge; src_ready=0 during rst; after release, rr_ptr=0.
- Single write: source 2 valid, addr=5, data=0xDEAD → src_ready=4'b0100 that cycle; next cycle wr_en=1, wr_addr=5, wr_onehot=0x20, wr_data=0xDEAD; one cycle later wr_en=0.
- Round-robin: all 4 sources valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; wr_en high all 8 following cycles.
- R0 write: source 1 addr=0 → src_ready[1]=1; next cycle wr_en=0, wr_onehot=0; busy unchanged.
- Scoreboard: issue addr 9 at edge E → busy[9]=1; source 0 writes addr 9, granted at edge E+3 → wr_en high after E+3; busy[9]=0 after E+4.
- Set/clear collision: wr_en=1, wr_addr=12, with issue_valid=1, issue_addr=12 on the same edge → busy[12] stays 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the single register file write port,
// plus a pending-write scoreboard used by the issue stage for hazard stalls.
module regfile_wb_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [6*NUM_SRC-1:0]      src_addr,
   input  logic [DATA_W*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      wr_en,
   output logic [5:0]                wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic [63:0]               wr_onehot,
   input  logic                      issue_valid,
   input  logic [5:0]                issue_addr,
   output logic [63:0]               busy
);

   localparam int MAX_SRC = 8;

   logic [2:0]        rr_ptr;
   logic [MAX_SRC-1:0] valid_pad;
   logic [5:0]        addr_arr [MAX_SRC];
   logic [DATA_W-1:0] data_arr [MAX_SRC];
   logic              grant_found;
   logic              transfer;
   logic [2:0]        grant_idx;
   logic [3:0]        cand;
   logic [5:0]        grant_addr;
   logic [63:0]       busy_next;

   // Pad the per-source buses to 8 entries so a 3-bit index is always in range.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      valid_pad = '0;
      for (int i = 0; i < MAX_SRC; i++) begin
         addr_arr[i] = '0;
         data_arr[i] = '0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         valid_pad[i] = src_valid[i];
         addr_arr[i]  = src_addr[6*i +: 6];
         data_arr[i]  = src_data[DATA_W*i +: DATA_W];
      end
   end

   // Scan from lowest priority to highest so the last hit (closest to rr_ptr) wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr} + 4'(k);
         if (cand >= 4'(NUM_SRC))
            cand = cand - 4'(NUM_SRC);
         if (valid_pad[cand[2:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[2:0];
         end
      end
   end

   assign transfer   = grant_found & ~rst;
   assign grant_addr = addr_arr[grant_idx];

   always_comb begin
      src_ready = '0;
      for (int i = 0; i < NUM_SRC; i++)
         src_ready[i] = transfer && (grant_idx == 3'(i));
   end

   // Clear is applied before set so a new producer to the same register stays pending.
   always_comb begin
      busy_next = busy;
      if (wr_en)
         busy_next[wr_addr] = 1'b0;
      if (issue_valid && issue_addr != 6'd0)
         busy_next[issue_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         rr_ptr    <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_onehot <= '0;
         busy      <= '0;
      end else begin
         busy <= busy_next;
         if (transfer) begin
            wr_addr   <= grant_addr;
            wr_data   <= data_arr[grant_idx];
            wr_en     <= (grant_addr != 6'd0);
            wr_onehot <= (grant_addr != 6'd0) ? (64'd1 << grant_addr) : 64'd0;
            rr_ptr    <= (grant_idx == 3'(NUM_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;
         end else begin
            wr_en     <= 1'b0;
            wr_onehot <= '0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference model predicts grant,
// write-port and busy values, which are queued and compared after each edge.
module tb_regfile_wb_arbiter;

   localparam int NUM_SRC = 4;
   localparam int DATA_W  = 64;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [NUM_SRC-1:0]        src_valid = '0;
   logic [6*NUM_SRC-1:0]      src_addr = '0;
   logic [DATA_W*NUM_SRC-1:0] src_data = '0;
   logic [NUM_SRC-1:0]        src_ready;
   logic                      wr_en;
   logic [5:0]                wr_addr;
   logic [DATA_W-1:0]         wr_data;
   logic [63:0]               wr_onehot;
   logic                      issue_valid = 1'b0;
   logic [5:0]                issue_addr = '0;
   logic [63:0]               busy;

   regfile_wb_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .src_valid   (src_valid),
      .src_addr    (src_addr),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_onehot   (wr_onehot),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [5:0]  addr;
      logic [63:0] data;
      logic [63:0] onehot;
      logic [63:0] busy;
   } exp_t;

   exp_t sb_q[$];

   int total = 0;
   int bad   = 0;

   int          m_ptr    = 0;
   logic        m_en     = 1'b0;
   logic [5:0]  m_addr   = '0;
   logic [63:0] m_data   = '0;
   logic [63:0] m_onehot = '0;
   logic [63:0] m_busy   = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int model_grant(input logic [NUM_SRC-1:0] v, input int ptr);
      for (int k = 0; k < NUM_SRC; k++) begin
         if (v[(ptr + k) % NUM_SRC])
            return (ptr + k) % NUM_SRC;
      end
      return -1;
   endfunction

   task automatic set_src(input int i, input logic v, input logic [5:0] a, input logic [63:0] d);
      src_valid[i]         = v;
      src_addr[6*i +: 6]   = a;
      src_data[64*i +: 64] = d;
   endtask

   task automatic clear_src();
      src_valid = '0;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_onehot = '0; m_busy = '0;
      sb_q.delete();
   endtask

   // Called after inputs are driven on the falling edge; checks the grant,
   // predicts the next edge, then compares the write port and scoreboard.
   task automatic cycle();
      int               g;
      logic [NUM_SRC-1:0] exp_ready;
      exp_t             e;
      #1;
      g = model_grant(src_valid, m_ptr);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("src_ready", 64'(src_ready), 64'(exp_ready));
      if (m_en) m_busy[m_addr] = 1'b0;
      if (issue_valid && issue_addr != 6'd0) m_busy[issue_addr] = 1'b1;
      if (g >= 0) begin
         m_addr   = src_addr[6*g +: 6];
         m_data   = src_data[64*g +: 64];
         m_en     = (m_addr != 6'd0);
         m_onehot = '0;
         if (m_en) m_onehot[m_addr] = 1'b1;
         m_ptr    = (g + 1) % NUM_SRC;
      end else begin
         m_en     = 1'b0;
         m_onehot = '0;
      end
      sb_q.push_back('{m_en, m_addr, m_data, m_onehot, m_busy});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("wr_en", 64'(wr_en), 64'(e.en));
      check("wr_addr", 64'(wr_addr), 64'(e.addr));
      check("wr_data", wr_data, e.data);
      check("wr_onehot", wr_onehot, e.onehot);
      check("busy", busy, e.busy);
   endtask

   initial begin
      // Reset values, with every source requesting to show ready is held low.
      src_valid = '1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 64'(src_ready), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      check("rst_wr_data", wr_data, 64'd0);
      check("rst_wr_onehot", wr_onehot, 64'd0);
      check("rst_busy", busy, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_src();
      model_reset();

      // Round-robin: all four sources continuously valid for eight grants.
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_SRC; i++)
            set_src(i, 1'b1, 6'(10 + i), {32'hA000_0000 + 32'(c), 32'(i)});
         cycle();
      end

      // Single write from source 2.
      @(negedge clk);
      clear_src();
      set_src(2, 1'b1, 6'd5, 64'hDEAD);
      cycle();
      @(negedge clk);
      clear_src();
      cycle();
      check("single_wr_idle", 64'(wr_en), 64'd0);

      // Write to register 0: handshake completes, no write enable.
      @(negedge clk);
      set_src(1, 1'b1, 6'd0, 64'h1234_5678);
      cycle();
      @(negedge clk);
      clear_src();
      cycle();

      // Scoreboard: issue r9, write it back three edges later.
      @(negedge clk);
      issue_valid = 1'b1;
      issue_addr  = 6'd9;
      cycle();
      @(negedge clk);
      issue_valid = 1'b0;
      cycle();
      @(negedge clk);
      cycle();
      @(negedge clk);
      set_src(0, 1'b1, 6'd9, 64'h9999);
      cycle();
      @(negedge clk);
      clear_src();
      cycle();
      check("busy9_cleared", 64'(busy[9]), 64'd0);

      // Set/clear collision on r12.
      @(negedge clk);
      issue_valid = 1'b1;
      issue_addr  = 6'd12;
      cycle();
      @(negedge clk);
      issue_valid = 1'b0;
      set_src(3, 1'b1, 6'd12, 64'hC0C0);
      cycle();
      @(negedge clk);
      clear_src();
      issue_valid = 1'b1;
      issue_addr  = 6'd12;
      cycle();
      check("busy12_collision", 64'(busy[12]), 64'd1);
      @(negedge clk);
      issue_valid = 1'b0;
      cycle();

      // Random traffic, including withdrawn requests and r0 targets.
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_SRC; i++)
            set_src(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), {$urandom, $urandom});
         issue_valid = 1'($urandom_range(0, 1));
         issue_addr  = 6'($urandom_range(0, 63));
         cycle();
      end

      // Asynchronous reset while a write is on the port.
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++)
         set_src(i, 1'b1, 6'(20 + i), 64'(40 + i));
      issue_valid = 1'b1;
      issue_addr  = 6'd33;
      cycle();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_wr_en", 64'(wr_en), 64'd0);
      check("arst_wr_onehot", wr_onehot, 64'd0);
      check("arst_busy", busy, 64'd0);
      check("arst_ready", 64'(src_ready), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      issue_valid = 1'b0;
      cycle();
      @(negedge clk);
      clear_src();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
